ps2_key_source: RTL and testbench

Converts the raw two-wire PS/2 keyboard line (clock + data, device-driven) into the 11-bit `ps2_key` event word that the core top level consumes for keyboard controls. Sits between the user-port/IO pins and the core's key-decoding logic, replacing the HPS-provided `ps2_key` when a physical keyboard is attached. It deserializes frames, checks framing and parity, and folds the E0/F0 prefix bytes into single press/release events. Receive-only: it never drives the PS/2 lines.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_filter.sv | 50 +++++
 rtl/ps2_key_source.sv | 135 +++++++++++++
 tb/tb_ps2_key_source.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame FSM states, prefix byte codes, ps2_key field positions.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    localparam int KEY_TOG = 10;
    localparam int KEY_PRS = 9;
    localparam int KEY_EXT = 8;

    // Number of consecutive identical samples before the filtered clock follows the pin.
    localparam int FILT_LEN   = 4;
    localparam int FILT_CNT_W = $clog2(FILT_LEN);

    // Odd parity over data+parity, and a high stop bit.
    function automatic logic frame_ok(input logic [7:0] data, input logic par, input logic stop);
        return stop & (^data ^ par);
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// 2-FF synchronizer, 4-sample glitch filter and registered falling-edge strobe for the PS/2 clock pin.
// Strobe follows a clean raw falling edge by 6 cycles; flops reset high to match an idle line.
module ps2_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic fall_o
);

    localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_LEN - 1);

    logic                  s1_q, s2_q;
    logic                  filt_q, filt_d;
    logic [FILT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  fall_q;

    // Count samples that disagree with the filtered level; any agreeing sample restarts the count.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (s2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= pin_i;
            s2_q   <= s1_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            fall_q <= filt_q & ~filt_d;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_key_source.sv
// PS/2 keyboard receiver producing the 11-bit ps2_key event word; event lands 7 cycles after the stop-bit clock edge.
// Receive-only, no back-pressure: consumers detect events by watching ps2_key[10] toggle.
module ps2_key_source
    import ps2_pkg::*;
#(
    parameter real CLK_FREQ   = 96.0,
    parameter int  TIMEOUT_US = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam real TMO_REAL  = CLK_FREQ * TIMEOUT_US;
    localparam int  TMO_FLOOR = $rtoi(TMO_REAL);
    localparam int  TMO_CYC   = (TMO_REAL > real'(TMO_FLOOR)) ? TMO_FLOOR + 1 : TMO_FLOOR;
    localparam int  TMO_W     = $clog2(TMO_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic             strobe;
    logic             data_s1_q, data_s2_q;
    ps2_state_e       state_q;
    logic [7:0]       shift_q;
    logic [2:0]       bitcnt_q;
    logic             par_q;
    logic [TMO_W-1:0] tmo_q;
    logic             ext_q, brk_q;
    logic [10:0]      key_q;
    logic             err_q;
    logic [10:0]      key_d;

    ps2_filter u_clk_filter (
        .clk    (clk),
        .reset  (reset),
        .pin_i  (ps2_clk),
        .fall_o (strobe)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_s1_q <= 1'b1;
            data_s2_q <= 1'b1;
        end else begin
            data_s1_q <= ps2_data;
            data_s2_q <= data_s1_q;
        end
    end

    always_comb begin
        key_d          = key_q;
        key_d[7:0]     = shift_q;
        key_d[KEY_EXT] = ext_q;
        key_d[KEY_PRS] = ~brk_q;
        key_d[KEY_TOG] = ~key_q[KEY_TOG];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            key_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state_q != ST_IDLE) begin
                tmo_q <= strobe ? '0 : tmo_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (strobe && !data_s2_q) begin
                        state_q  <= ST_DATA;
                        bitcnt_q <= '0;
                        tmo_q    <= '0;
                    end
                end
                ST_DATA: begin
                    if (strobe) begin
                        shift_q  <= {data_s2_q, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    if (strobe) begin
                        par_q   <= data_s2_q;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (strobe) begin
                        state_q <= ST_IDLE;
                        if (frame_ok(shift_q, par_q, data_s2_q)) begin
                            if (shift_q == PS2_EXT) begin
                                ext_q <= 1'b1;
                            end else if (shift_q == PS2_BRK) begin
                                brk_q <= 1'b1;
                            end else if (shift_q != PS2_PAUSE) begin
                                key_q <= key_d;
                                ext_q <= 1'b0;
                                brk_q <= 1'b0;
                            end
                        end else begin
                            err_q <= 1'b1;
                            ext_q <= 1'b0;
                            brk_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // A stalled frame is abandoned like a corrupt one.
            if (state_q != ST_IDLE && !strobe && tmo_q == TMO_LAST) begin
                state_q <= ST_IDLE;
                tmo_q   <= '0;
                err_q   <= 1'b1;
                ext_q   <= 1'b0;
                brk_q   <= 1'b0;
            end
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_source.sv
// Self-checking bench for ps2_key_source: frame table plus timeout, glitch and mid-frame reset sequences.
module tb_ps2_key_source;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    always #5 clk = ~clk;

    // 1 MHz x 200 us gives a 200-cycle frame timeout; bit period below is 40 cycles.
    ps2_key_source #(.CLK_FREQ(1.0), .TIMEOUT_US(200)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err)
    );

    typedef struct {
        logic [7:0]  code;
        bit          bad_par;
        bit          bad_stop;
        int          kind;    // 0 no output, 1 key event, 2 frame_err pulse
        logic [10:0] key;
    } vec_t;

    typedef struct {
        bit          is_err;
        logic [10:0] key;
        bit          chk_lat;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_fall = 0;
    logic [10:0] prev_key = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_err, input logic [10:0] key, input bit chk_lat);
        exp_t e;
        e.is_err  = is_err;
        e.key     = key;
        e.chk_lat = chk_lat;
        sb.push_back(e);
    endtask

    task automatic send_bits(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                             input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            tick(10);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            tick(20);
            ps2_clk = 1'b1;
            tick(10);
        end
        ps2_data = 1'b1;
    endtask

    task automatic check_out(input bit is_err, input logic [10:0] key);
        exp_t e;
        int   lat;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_output: got err=%0d key=%03h, required no output", is_err, key);
        end else begin
            e = sb.pop_front();
            if (e.is_err != is_err || (!is_err && key !== e.key)) begin
                fails++;
                $display("FAIL output_match: got err=%0d key=%03h, required err=%0d key=%03h",
                         is_err, key, e.is_err, e.key);
            end
            if (e.chk_lat) begin
                lat = cyc - last_fall;
                tests++;
                if (lat < 1 || lat > 8) begin
                    fails++;
                    $display("FAIL latency: got %0d cycles after stop edge, required 1..8", lat);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_key = ps2_key;
        end else begin
            if (ps2_key !== prev_key) begin
                check_out(1'b0, ps2_key);
                prev_key = ps2_key;
            end
            if (frame_err) check_out(1'b1, ps2_key);
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            tick(1);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain_%s: got %0d outputs still outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_val(input string name, input logic [10:0] got, input logic [10:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %03h, required %03h", name, got, req);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        vec_t vt[17];
        vt[0]  = '{8'h1C, 1'b0, 1'b0, 1, 11'h61C};
        vt[1]  = '{8'hE0, 1'b0, 1'b0, 0, 11'h000};
        vt[2]  = '{8'hF0, 1'b0, 1'b0, 0, 11'h000};
        vt[3]  = '{8'h75, 1'b0, 1'b0, 1, 11'h175};
        vt[4]  = '{8'h29, 1'b0, 1'b0, 1, 11'h629};
        vt[5]  = '{8'hF0, 1'b0, 1'b0, 0, 11'h000};
        vt[6]  = '{8'h16, 1'b1, 1'b0, 2, 11'h000};
        vt[7]  = '{8'h16, 1'b0, 1'b0, 1, 11'h216};
        vt[8]  = '{8'hE0, 1'b0, 1'b0, 0, 11'h000};
        vt[9]  = '{8'h12, 1'b0, 1'b1, 2, 11'h000};
        vt[10] = '{8'h12, 1'b0, 1'b0, 1, 11'h612};
        vt[11] = '{8'hE1, 1'b0, 1'b0, 0, 11'h000};
        vt[12] = '{8'hF0, 1'b0, 1'b0, 0, 11'h000};
        vt[13] = '{8'hE1, 1'b0, 1'b0, 0, 11'h000};
        vt[14] = '{8'h1C, 1'b0, 1'b0, 1, 11'h01C};
        vt[15] = '{8'hE0, 1'b0, 1'b0, 0, 11'h000};
        vt[16] = '{8'h4A, 1'b0, 1'b0, 1, 11'h74A};

        reset = 1'b1;
        tick(5);
        check_val("reset_key", ps2_key, 11'h000);
        check_val("reset_err", {10'd0, frame_err}, 11'h000);
        reset = 1'b0;
        tick(1000);
        check_val("idle_key", ps2_key, 11'h000);

        for (int i = 0; i < 17; i++) begin
            if (vt[i].kind == 1) push(1'b0, vt[i].key, 1'b1);
            if (vt[i].kind == 2) push(1'b1, 11'h000, 1'b1);
            send_bits(vt[i].code, vt[i].bad_par, vt[i].bad_stop, 11);
            tick(20);
        end
        drain("table");

        // Start bit plus five data bits, then silence until the timeout fires.
        push(1'b1, 11'h000, 1'b0);
        send_bits(8'h14, 1'b0, 1'b0, 6);
        tick(250);
        drain("timeout");
        push(1'b0, 11'h214, 1'b1);
        send_bits(8'h14, 1'b0, 1'b0, 11);
        drain("after_timeout");

        ps2_clk = 1'b0;
        tick(2);
        ps2_clk = 1'b1;
        tick(50);
        check_val("glitch_key", ps2_key, 11'h214);

        send_bits(8'h5A, 1'b0, 1'b0, 4);
        #3;
        reset = 1'b1;
        #1;
        check_val("midreset_key", ps2_key, 11'h000);
        check_val("midreset_err", {10'd0, frame_err}, 11'h000);
        tick(3);
        reset = 1'b0;
        tick(300);
        check_val("post_reset_key", ps2_key, 11'h000);
        push(1'b0, 11'h65A, 1'b1);
        send_bits(8'h5A, 1'b0, 1'b0, 11);
        drain("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
